// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the two-port SDRAM command arbiter.
package sdram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT_A = 3'd1,
        ST_GRANT_B = 3'd2,
        ST_WAIT_A  = 3'd3,
        ST_WAIT_B  = 3'd4
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter: grants one client port at a time to the SDRAM controller
// and routes that port's completion back to it.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    output logic [ADDR_WIDTH-1:0] ctrl_addr_o,
    output logic [DATA_WIDTH-1:0] ctrl_write_data_o,
    output logic                  ctrl_wr_o,
    output logic                  ctrl_rd_o,
    input  logic                  ctrl_rdy_i,
    input  logic                  ctrl_wvalid_i,
    input  logic                  ctrl_rvalid_i,
    input  logic [DATA_WIDTH-1:0] ctrl_read_data_i,

    input  logic [ADDR_WIDTH-1:0] porta_addr_i,
    input  logic [DATA_WIDTH-1:0] porta_write_data_i,
    input  logic                  porta_wr_i,
    input  logic                  porta_rd_i,
    output logic                  porta_rdy_o,
    output logic                  porta_wvalid_o,
    output logic                  porta_rvalid_o,
    output logic [DATA_WIDTH-1:0] porta_read_data_o,

    input  logic [ADDR_WIDTH-1:0] portb_addr_i,
    input  logic [DATA_WIDTH-1:0] portb_write_data_i,
    input  logic                  portb_wr_i,
    input  logic                  portb_rd_i,
    output logic                  portb_rdy_o,
    output logic                  portb_wvalid_o,
    output logic                  portb_rvalid_o,
    output logic [DATA_WIDTH-1:0] portb_read_data_o
);

    arb_state_t state_q, state_d;
    port_sel_t  last_q, last_d;
    logic       op_wr_q, op_wr_d;

    logic req_a;
    logic req_b;

    assign req_a = porta_rd_i | porta_wr_i;
    assign req_b = portb_rd_i | portb_wr_i;

    // Read data is broadcast; only the owner's rvalid qualifies it.
    assign porta_read_data_o = ctrl_read_data_i;
    assign portb_read_data_o = ctrl_read_data_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= PORT_B;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            op_wr_q <= op_wr_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        last_d            = last_q;
        op_wr_d           = op_wr_q;
        ctrl_addr_o       = '0;
        ctrl_write_data_o = '0;
        ctrl_wr_o         = 1'b0;
        ctrl_rd_o         = 1'b0;
        porta_rdy_o       = 1'b0;
        porta_wvalid_o    = 1'b0;
        porta_rvalid_o    = 1'b0;
        portb_rdy_o       = 1'b0;
        portb_wvalid_o    = 1'b0;
        portb_rvalid_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On contention the port that was not granted last wins.
                if (req_a && (!req_b || last_q == PORT_B)) begin
                    state_d = ST_GRANT_A;
                    last_d  = PORT_A;
                end else if (req_b) begin
                    state_d = ST_GRANT_B;
                    last_d  = PORT_B;
                end
            end

            ST_GRANT_A: begin
                ctrl_addr_o       = porta_addr_i;
                ctrl_write_data_o = porta_write_data_i;
                ctrl_wr_o         = porta_wr_i;
                ctrl_rd_o         = porta_rd_i & ~porta_wr_i;
                porta_rdy_o       = ctrl_rdy_i;
                if (!req_a) begin
                    state_d = ST_IDLE;
                end else if (ctrl_rdy_i) begin
                    op_wr_d = porta_wr_i;
                    state_d = ST_WAIT_A;
                end
            end

            ST_GRANT_B: begin
                ctrl_addr_o       = portb_addr_i;
                ctrl_write_data_o = portb_write_data_i;
                ctrl_wr_o         = portb_wr_i;
                ctrl_rd_o         = portb_rd_i & ~portb_wr_i;
                portb_rdy_o       = ctrl_rdy_i;
                if (!req_b) begin
                    state_d = ST_IDLE;
                end else if (ctrl_rdy_i) begin
                    op_wr_d = portb_wr_i;
                    state_d = ST_WAIT_B;
                end
            end

            ST_WAIT_A: begin
                porta_wvalid_o = ctrl_wvalid_i;
                porta_rvalid_o = ctrl_rvalid_i;
                if (op_wr_q ? ctrl_wvalid_i : ctrl_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_B: begin
                portb_wvalid_o = ctrl_wvalid_i;
                portb_rvalid_o = ctrl_rvalid_i;
                if (op_wr_q ? ctrl_wvalid_i : ctrl_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized scoreboard bench for sdram_arbiter with a behavioural SDRAM
// controller, per-port expected-response queues and a grant-order log.
module tb_sdram_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ctrl_addr;
    logic [DW-1:0] ctrl_wdata;
    logic          ctrl_wr, ctrl_rd;
    logic          ctrl_rdy, ctrl_wvalid, ctrl_rvalid;
    logic [DW-1:0] ctrl_rdata;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_wr, a_rd, b_wr, b_rd;
    logic          a_rdy, a_wvalid, a_rvalid, b_rdy, b_wvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .ctrl_addr_o(ctrl_addr), .ctrl_write_data_o(ctrl_wdata),
        .ctrl_wr_o(ctrl_wr), .ctrl_rd_o(ctrl_rd), .ctrl_rdy_i(ctrl_rdy),
        .ctrl_wvalid_i(ctrl_wvalid), .ctrl_rvalid_i(ctrl_rvalid),
        .ctrl_read_data_i(ctrl_rdata),
        .porta_addr_i(a_addr), .porta_write_data_i(a_wdata),
        .porta_wr_i(a_wr), .porta_rd_i(a_rd), .porta_rdy_o(a_rdy),
        .porta_wvalid_o(a_wvalid), .porta_rvalid_o(a_rvalid),
        .porta_read_data_o(a_rdata),
        .portb_addr_i(b_addr), .portb_write_data_i(b_wdata),
        .portb_wr_i(b_wr), .portb_rd_i(b_rd), .portb_rdy_o(b_rdy),
        .portb_wvalid_o(b_wvalid), .portb_rvalid_o(b_rvalid),
        .portb_read_data_o(b_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_wr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_a[$];
    exp_t          sb_b[$];
    int            grant_log[$];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    logic [DW-1:0] dev_mem[logic [AW-1:0]];
    int            n_total = 0;
    int            n_pass  = 0;
    int            outstanding = 0;  // 0 none, 1 port A, 2 port B
    int            b_rdy_seen = 0;
    int            b_valid_seen = 0;
    int            accept_count = 0;
    int            min_lat = 1;
    int            max_lat = 3;
    bit            stall = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic port_rdy(input int p);
        return (p == 0) ? a_rdy : b_rdy;
    endfunction

    function automatic logic port_done(input int p);
        return (p == 0) ? (a_wvalid | a_rvalid) : (b_wvalid | b_rvalid);
    endfunction

    task automatic drive(input int p, input logic wr, input logic rd,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (p == 0) begin
            a_wr = wr; a_rd = rd; a_addr = addr; a_wdata = wdata;
        end else begin
            b_wr = wr; b_rd = rd; b_addr = addr; b_wdata = wdata;
        end
    endtask

    // One client transaction: expectation queued at issue, checked by the monitor.
    task automatic do_op(input int p, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        e.is_wr = wr;
        e.data  = wr ? wdata : (ref_mem.exists(addr) ? ref_mem[addr] : '0);
        if (wr) ref_mem[addr] = wdata;
        if (p == 0) sb_a.push_back(e); else sb_b.push_back(e);
        drive(p, wr, ~wr, addr, wdata);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen && !rst; i++) begin
            @(negedge clk);
            if (port_rdy(p)) seen = 1'b1;
        end
        if (rst) begin
            drive(p, 1'b0, 1'b0, '0, '0);
            return;
        end
        if (!seen) begin
            chk("accept_timeout", 64'(p), 64'(p + 100));
            drive(p, 1'b0, 1'b0, '0, '0);
            return;
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, '0, '0);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen && !rst; i++) begin
            @(negedge clk);
            if (port_done(p)) seen = 1'b1;
        end
        if (!seen && !rst) chk("complete_timeout", 64'(p), 64'(p + 100));
    endtask

    task automatic wait_outstanding(input int v);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (outstanding == v) ok = 1'b1;
        end
        if (!ok) chk("wait_outstanding_timeout", 64'(outstanding), 64'(v));
    endtask

    task automatic completion(input int p, input logic wv, input logic rv,
                              input logic [DW-1:0] data);
        exp_t e;
        if ((p == 0 && sb_a.size() == 0) || (p == 1 && sb_b.size() == 0)) begin
            chk(p == 0 ? "spurious_valid_a" : "spurious_valid_b", 64'({wv, rv}), 64'(0));
            return;
        end
        e = (p == 0) ? sb_a.pop_front() : sb_b.pop_front();
        chk(p == 0 ? "optype_a" : "optype_b", 64'({wv, rv}), 64'({e.is_wr, ~e.is_wr}));
        if (!e.is_wr) chk(p == 0 ? "rdata_a" : "rdata_b", 64'(data), 64'(e.data));
        chk("completion_owner", 64'(outstanding), 64'(p + 1));
        outstanding = 0;
    endtask

    // Monitor: completions, acceptances and isolation observed mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (b_rdy) b_rdy_seen++;
            if (b_wvalid || b_rvalid) b_valid_seen++;
            if (a_wvalid || a_rvalid) completion(0, a_wvalid, a_rvalid, a_rdata);
            if (b_wvalid || b_rvalid) completion(1, b_wvalid, b_rvalid, b_rdata);
            if (!rst && a_rdy && (a_rd || a_wr)) begin
                chk("single_outstanding_a", 64'(outstanding), 64'(0));
                outstanding = 1;
                grant_log.push_back(0);
            end
            if (!rst && b_rdy && (b_rd || b_wr)) begin
                chk("single_outstanding_b", 64'(outstanding), 64'(0));
                outstanding = 2;
                grant_log.push_back(1);
            end
        end
    end

    // Behavioural SDRAM controller: accepts when ready, completes after a random delay.
    initial begin
        logic          busy = 1'b0;
        logic          cwr = 1'b0;
        logic [AW-1:0] caddr = '0;
        logic [DW-1:0] cwd = '0;
        int            cnt = 0;
        ctrl_rdy = 1'b0; ctrl_wvalid = 1'b0; ctrl_rvalid = 1'b0; ctrl_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && !busy && ctrl_rdy && (ctrl_rd || ctrl_wr)) begin
                busy  = 1'b1;
                cwr   = ctrl_wr;
                caddr = ctrl_addr;
                cwd   = ctrl_wdata;
                cnt   = $urandom_range(max_lat, min_lat);
                accept_count++;
            end
            @(posedge clk); #1;
            ctrl_wvalid = 1'b0;
            ctrl_rvalid = 1'b0;
            ctrl_rdata  = $urandom;
            if (busy) begin
                if (cnt == 0) begin
                    if (cwr) begin
                        dev_mem[caddr] = cwd;
                        ctrl_wvalid = 1'b1;
                    end else begin
                        ctrl_rdata  = dev_mem.exists(caddr) ? dev_mem[caddr] : '0;
                        ctrl_rvalid = 1'b1;
                    end
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
            ctrl_rdy = !busy && !stall && ($urandom_range(3, 0) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] rand_addr(input int p);
        return AW'(32'h0001_0000 * (p + 1) + 4 * $urandom_range(7, 0));
    endfunction

    initial begin
        int acc0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({a_rdy, a_wvalid, a_rvalid, b_rdy, b_wvalid, b_rvalid,
                                  ctrl_rd, ctrl_wr}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention straight out of reset: A wins first.
        grant_log.delete();
        fork
            do_op(0, 1'b1, 32'h0000_0100, 32'h1111_AAAA);
            do_op(1, 1'b1, 32'h0000_0200, 32'h2222_BBBB);
        join
        fork
            do_op(0, 1'b0, 32'h0000_0100, '0);
            do_op(1, 1'b0, 32'h0000_0200, '0);
        join
        chk("contention_grants", 64'(grant_log.size()), 64'(4));
        if (grant_log.size() >= 2) begin
            chk("contention_first_A", 64'(grant_log[0]), 64'(0));
            chk("contention_then_B", 64'(grant_log[1]), 64'(1));
        end

        // Directed write/read on A with B silent.
        repeat (2) @(posedge clk);
        b_rdy_seen = 0;
        b_valid_seen = 0;
        do_op(0, 1'b1, 32'h0012_3454, 32'hDEAD_BEEF);
        do_op(0, 1'b0, 32'h0012_3454, '0);
        chk("b_quiet_rdy", 64'(b_rdy_seen), 64'(0));
        chk("b_quiet_valid", 64'(b_valid_seen), 64'(0));

        // Fairness: both ports request back-to-back.
        repeat (2) @(posedge clk);
        grant_log.delete();
        fork
            repeat (5) do_op(0, 1'($urandom_range(1, 0)), rand_addr(0), $urandom);
            repeat (5) do_op(1, 1'($urandom_range(1, 0)), rand_addr(1), $urandom);
        join
        chk("fairness_grants", 64'(grant_log.size()), 64'(10));
        for (int i = 1; i < grant_log.size(); i++)
            chk("fairness_alternate", 64'(grant_log[i] != grant_log[i-1]), 64'(1));

        // Random traffic with gaps.
        fork
            repeat (12) begin
                repeat ($urandom_range(3, 0)) @(posedge clk);
                do_op(0, 1'($urandom_range(1, 0)), rand_addr(0), $urandom);
            end
            repeat (12) begin
                repeat ($urandom_range(3, 0)) @(posedge clk);
                do_op(1, 1'($urandom_range(1, 0)), rand_addr(1), $urandom);
            end
        join

        // Isolation: B write waits behind a slow A read.
        min_lat = 4; max_lat = 6;
        grant_log.delete();
        fork
            do_op(0, 1'b0, rand_addr(0), '0);
            begin
                wait_outstanding(1);
                do_op(1, 1'b1, rand_addr(1), 32'hCAFE_F00D);
            end
        join
        chk("isolation_grants", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() == 2) begin
            chk("isolation_first_A", 64'(grant_log[0]), 64'(0));
            chk("isolation_then_B", 64'(grant_log[1]), 64'(1));
        end
        min_lat = 1; max_lat = 3;

        // Withdrawn B read: no controller command, arbiter frees up for A.
        @(posedge clk); #1;
        stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        acc0 = accept_count;
        grant_log.delete();
        drive(1, 1'b0, 1'b1, 32'h0000_0300, '0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("withdraw_no_rdy", 64'(b_rdy), 64'(0));
        stall = 1'b0;
        do_op(0, 1'b1, rand_addr(0), 32'h5A5A_0F0F);
        chk("withdraw_accepts", 64'(accept_count - acc0), 64'(1));
        chk("withdraw_grant_log", 64'(grant_log.size()), 64'(1));
        if (grant_log.size() == 1) chk("withdraw_then_A", 64'(grant_log[0]), 64'(0));

        // Asynchronous reset while A waits for a write completion.
        min_lat = 6; max_lat = 8;
        fork
            do_op(0, 1'b1, 32'h0000_0400, 32'h7777_1234);
        join_none
        wait_outstanding(1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({a_rdy, a_wvalid, a_rvalid, b_rdy, b_wvalid, b_rvalid,
                                        ctrl_rd, ctrl_wr, ctrl_addr}), 64'(0));
        sb_a.delete();
        sb_b.delete();
        outstanding = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        min_lat = 1; max_lat = 3;
        repeat (12) @(posedge clk);
        grant_log.delete();
        do_op(1, 1'b1, 32'h0000_0500, 32'h0BAD_CAFE);
        do_op(1, 1'b0, 32'h0000_0500, '0);
        do_op(0, 1'b0, 32'h0000_0400, '0);
        chk("post_reset_grants", 64'(grant_log.size()), 64'(3));

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 64'(sb_a.size() + sb_b.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port round-robin arbiter between client ports A and B and a single SDRAM controller command port.
- Each client uses the standard `sdram_ctrl_if` request/ready/valid protocol.
- The arbiter grants one port at a time and forwards that port's command to the controller (`sdram_core`).
- It holds the grant until the controller reports completion, then routes completion and read data back to the owning port.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of `addr` on all three interfaces
- DATA_WIDTH, 32, width of `write_data`/`read_data` on all three interfaces

Ports:
- clk  in  1  single system clock; all state on rising edge
- rst  in  1  reset; asynchronous and active-high
- ctrl_if  `sdram_ctrl_if.man`  bundle  to controller
- portA_if  `sdram_ctrl_if.sub`  bundle  client A
- portB_if  `sdram_ctrl_if.sub`  bundle  client B

Bundle signals (direction from the client side):
- addr  out  ADDR_WIDTH
- write_data  out  DATA_WIDTH
- wr  out  1
- rd  out  1
- rdy  in  1  request accepted at this edge
- wvalid  in  1  one-cycle write-complete pulse
- rvalid  in  1  one-cycle read-data-valid pulse
- read_data  in  DATA_WIDTH  valid with rvalid

## Operation
- States: IDLE, GRANT_A, GRANT_B, WAIT_A, WAIT_B. Encoding is free.
- `last` flag records the most recently granted port. Reset value: B, so A has first priority.
- IDLE, request present (rd|wr on a port):
  - Only A requesting: GRANT_A.
  - Only B requesting: GRANT_B.
  - Both requesting: grant the port other than `last`.
  - Set `last` to the granted port.
- GRANT_x:
  - ctrl addr/write_data/rd/wr = port x signals (combinational mux).
  - port x rdy = ctrl rdy. The other port's rdy = 0.
  - Acceptance occurs on a clock edge with ctrl rdy & (rd|wr): latch op type (write if wr, else read), go to WAIT_x.
  - If port x drops both rd and wr before acceptance: return to IDLE.
- WAIT_x:
  - ctrl rd/wr = 0.
  - Exit to IDLE on ctrl wvalid (write op) or ctrl rvalid (read op).
  - Completion for the other op type is ignored.
- Completion routing (combinational, all states):
  - Owner port's wvalid/rvalid = ctrl wvalid/rvalid while in WAIT_owner; 0 otherwise.
  - Non-owner's wvalid/rvalid = 0.
  - read_data driven to both ports from ctrl read_data; only meaningful with rvalid.
- Simultaneous rd and wr on one port is illegal. The arbiter forwards wr only and treats the op as a write.
- Outside GRANT states: ctrl rd=wr=0, addr/write_data = 0, both port rdy = 0.
- Exactly one outstanding transaction at a time.

## Timing
- Reset (asynchronous, any time including mid-transaction):
  - State IDLE, `last`=B.
  - All port rdy/wvalid/rvalid = 0, ctrl rd/wr = 0.
  - An in-flight controller completion after reset is dropped.
- Grant latency: request seen in IDLE at edge N, GRANT at N+1. The command reaches the controller in the same cycle (N+1).
- Accepted at the ctrl rdy edge; WAIT entered next cycle.
- Completion pulse passes to the owner with zero added latency. IDLE follows at the next edge.
- Back-to-back: a port re-requesting immediately after completion waits 1 IDLE cycle. If the other port is pending, it wins.
- Clients hold addr/write_data/rd/wr stable until the rdy edge; the arbiter adds no buffering.

## Structure
- Shared package holds the arbiter state enum and a `port_sel_t` (A/B) type.
- Single module, no sub-modules; the muxes and FSM live in one file.
- Target size: about 150 lines.

## Test plan
- Single write then read on A: write 0xDEADBEEF to 0x00123454, wait for wvalid, read the same address -> rvalid with read_data 0xDEADBEEF; B sees no rdy/valid.
- Contention: A and B assert wr in the same cycle, right after reset -> A granted first, B granted after A's wvalid; both writes and reads return the correct data.
- Round-robin fairness: both ports request continuously for 10 transactions -> grants alternate A,B,A,B; no port is served twice in a row while the other is waiting.
- Routing isolation: A read pending while B issues a write request -> B rdy stays 0 until A's rvalid; A's rvalid never appears on B.
- Withdrawn request: B raises rd for 1 cycle then drops it before rdy -> FSM returns to IDLE, no controller command issued, A can be granted next.
- Async reset during WAIT_A -> all outputs 0 immediately; after release, the first request from either port is accepted normally.
